// File: rtl/pxie_rx_cmd_decoder_mc.sv
// PXIe downstream command decoder: control pulses, trigger parameters, C2H strobe,
// and address-incrementing burst writes into NUM_CH RAM channels.
`default_nettype none

module pxie_rx_cmd_decoder_mc #(
    parameter int DATA_W    = 128,
    parameter int NUM_CH    = 4,
    parameter int ADDR_W    = 32,
    parameter int PULSE_LEN = 50,
    parameter int TIMEOUT   = 1024
) (
    input  logic              I_PXIE_CLK,
    input  logic              I_Rst,
    input  logic [DATA_W-1:0] I_PXIE_DATA,
    input  logic              I_PXIE_DATA_VLD,
    output logic              O_Rst,
    output logic              O_Trig,
    output logic              O_Run,
    output logic [31:0]       O_Trig_Num,
    output logic [31:0]       O_Trig_Step,
    output logic [15:0]       O_c2h_addr,
    output logic [15:0]       O_c2h_len,
    output logic              O_c2h_en,
    output logic [NUM_CH-1:0] O_wr_en,
    output logic [ADDR_W-1:0] O_wr_addr,
    output logic [DATA_W-1:0] O_wr_data,
    output logic [15:0]       O_wr_num,
    output logic              O_busy,
    output logic              O_err,
    output logic [1:0]        O_err_code,
    output logic [15:0]       O_err_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] E_HDR = 2'd1;
    localparam logic [1:0] E_TMO = 2'd2;
    localparam logic [1:0] E_OVR = 2'd3;

    localparam int PW = $clog2(PULSE_LEN + 1) + 1;
    localparam int SW = $clog2(TIMEOUT + 1) + 1;

    logic [15:0] w_h, w_p;
    logic [31:0] w_l;
    assign w_h = I_PXIE_DATA[DATA_W-1 -: 16];
    assign w_p = I_PXIE_DATA[111:96];
    assign w_l = I_PXIE_DATA[31:0];

    logic [1:0]        state_q, state_d;
    logic              rst_q, rst_d, trig_q, trig_d, run_q, run_d;
    logic [31:0]       trig_num_q, trig_num_d, trig_step_q, trig_step_d;
    logic [15:0]       c2h_addr_q, c2h_addr_d, c2h_len_q, c2h_len_d;
    logic              c2h_en_q, c2h_en_d;
    logic [NUM_CH-1:0] wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, addr_q, addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [15:0]       wr_num_q, wr_num_d, rem_q, rem_d;
    logic [2:0]        ch_q, ch_d;
    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic [SW-1:0]     stall_q, stall_d;
    logic              err_q;
    logic [1:0]        err_code_q;
    logic [15:0]       err_cnt_q;
    logic              w_err_det;
    logic [1:0]        w_err_code;

    always_comb begin
        state_d     = state_q;
        rst_d       = rst_q;
        trig_d      = trig_q;
        run_d       = run_q;
        trig_num_d  = trig_num_q;
        trig_step_d = trig_step_q;
        c2h_addr_d  = c2h_addr_q;
        c2h_len_d   = c2h_len_q;
        c2h_en_d    = 1'b0;
        wr_en_d     = '0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_num_d    = wr_num_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        ch_d        = ch_q;
        pcnt_d      = pcnt_q;
        stall_d     = stall_q;
        w_err_det   = 1'b0;
        w_err_code  = 2'd0;
        case (state_q)
            S_IDLE: begin
                if (I_PXIE_DATA_VLD) begin
                    if (w_h == 16'hEB9C) begin
                        if (w_p == 16'd3) begin
                            trig_num_d = w_l;
                        end else if (w_p == 16'd4) begin
                            trig_step_d = w_l;
                        end else if (w_p == 16'd5) begin
                            c2h_addr_d = w_l[15:0];
                            c2h_len_d  = w_l[31:16];
                        end else begin
                            case (w_l[15:0])
                                16'h0001: begin state_d = S_PULSE; rst_d  = 1'b1; pcnt_d = '0; end
                                16'h0002: begin state_d = S_PULSE; trig_d = 1'b1; pcnt_d = '0; end
                                16'h1100: begin state_d = S_PULSE; run_d  = 1'b1; pcnt_d = '0; end
                                16'h1010: c2h_en_d = 1'b1;
                                default: begin w_err_det = 1'b1; w_err_code = E_HDR; end
                            endcase
                        end
                    end else if (w_h[15:8] == 8'hEB) begin
                        if (w_h[7:0] < 8'(NUM_CH)) begin
                            addr_d   = I_PXIE_DATA[ADDR_W-1:0];
                            wr_num_d = w_p;
                            rem_d    = w_p;
                            ch_d     = w_h[2:0];
                            stall_d  = '0;
                            if (w_p != 16'd0) state_d = S_BURST;
                        end else begin
                            w_err_det  = 1'b1;
                            w_err_code = E_HDR;
                        end
                    end
                end
            end
            S_PULSE: begin
                if (I_PXIE_DATA_VLD) begin
                    w_err_det  = 1'b1;
                    w_err_code = E_OVR;
                end
                pcnt_d = pcnt_q + PW'(1);
                // Pulse drops after PULSE_LEN cycles; one trailing PULSE cycle precedes DONE.
                if (pcnt_q == PW'(PULSE_LEN - 1)) begin
                    rst_d  = 1'b0;
                    trig_d = 1'b0;
                    run_d  = 1'b0;
                end
                if (pcnt_q == PW'(PULSE_LEN)) state_d = S_DONE;
            end
            S_BURST: begin
                if (I_PXIE_DATA_VLD) begin
                    for (int i = 0; i < NUM_CH; i++) wr_en_d[i] = (ch_q == 3'(i));
                    wr_addr_d = addr_q;
                    wr_data_d = I_PXIE_DATA;
                    addr_d    = addr_q + ADDR_W'(1);
                    rem_d     = rem_q - 16'd1;
                    stall_d   = '0;
                    if (rem_q == 16'd1) state_d = S_DONE;
                end else if (stall_q == SW'(TIMEOUT - 1)) begin
                    w_err_det  = 1'b1;
                    w_err_code = E_TMO;
                    state_d    = S_DONE;
                end else begin
                    stall_d = stall_q + SW'(1);
                end
            end
            default: begin
                if (I_PXIE_DATA_VLD) begin
                    w_err_det  = 1'b1;
                    w_err_code = E_OVR;
                end
                rst_d   = 1'b0;
                trig_d  = 1'b0;
                run_d   = 1'b0;
                pcnt_d  = '0;
                stall_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_PXIE_CLK or posedge I_Rst) begin
        if (I_Rst) begin
            state_q     <= S_IDLE;
            rst_q       <= 1'b0;
            trig_q      <= 1'b0;
            run_q       <= 1'b0;
            trig_num_q  <= '0;
            trig_step_q <= '0;
            c2h_addr_q  <= '0;
            c2h_len_q   <= '0;
            c2h_en_q    <= 1'b0;
            wr_en_q     <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_num_q    <= '0;
            addr_q      <= '0;
            rem_q       <= '0;
            ch_q        <= '0;
            pcnt_q      <= '0;
            stall_q     <= '0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rst_q       <= rst_d;
            trig_q      <= trig_d;
            run_q       <= run_d;
            trig_num_q  <= trig_num_d;
            trig_step_q <= trig_step_d;
            c2h_addr_q  <= c2h_addr_d;
            c2h_len_q   <= c2h_len_d;
            c2h_en_q    <= c2h_en_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_num_q    <= wr_num_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            ch_q        <= ch_d;
            pcnt_q      <= pcnt_d;
            stall_q     <= stall_d;
            err_q       <= w_err_det;
            if (w_err_det) begin
                err_code_q <= w_err_code;
                if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign O_Rst       = rst_q;
    assign O_Trig      = trig_q;
    assign O_Run       = run_q;
    assign O_Trig_Num  = trig_num_q;
    assign O_Trig_Step = trig_step_q;
    assign O_c2h_addr  = c2h_addr_q;
    assign O_c2h_len   = c2h_len_q;
    assign O_c2h_en    = c2h_en_q;
    assign O_wr_en     = wr_en_q;
    assign O_wr_addr   = wr_addr_q;
    assign O_wr_data   = wr_data_q;
    assign O_wr_num    = wr_num_q;
    assign O_busy      = (state_q != S_IDLE);
    assign O_err       = err_q;
    assign O_err_code  = err_code_q;
    assign O_err_cnt   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pxie_rx_cmd_decoder_mc.sv
// Directed bench for pxie_rx_cmd_decoder_mc; a second instance with ADDR_W=8 covers address wrap.
`default_nettype none

module tb_pxie_rx_cmd_decoder_mc;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] data;
    logic         vld;

    logic         o_rst, o_trig, o_run, c2h_en, busy, err;
    logic [31:0]  trig_num, trig_step, wr_addr;
    logic [15:0]  c2h_addr, c2h_len, wr_num, err_cnt;
    logic [3:0]   wr_en;
    logic [127:0] wr_data;
    logic [1:0]   err_code;

    logic         d2_rst, d2_trig, d2_run, d2_c2h_en, d2_busy, d2_err;
    logic [31:0]  d2_trig_num, d2_trig_step;
    logic [7:0]   d2_wr_addr;
    logic [15:0]  d2_c2h_addr, d2_c2h_len, d2_wr_num, d2_err_cnt;
    logic [3:0]   d2_wr_en;
    logic [127:0] d2_wr_data;
    logic [1:0]   d2_err_code;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pxie_rx_cmd_decoder_mc dut (
        .I_PXIE_CLK(clk), .I_Rst(rst), .I_PXIE_DATA(data), .I_PXIE_DATA_VLD(vld),
        .O_Rst(o_rst), .O_Trig(o_trig), .O_Run(o_run), .O_Trig_Num(trig_num),
        .O_Trig_Step(trig_step), .O_c2h_addr(c2h_addr), .O_c2h_len(c2h_len),
        .O_c2h_en(c2h_en), .O_wr_en(wr_en), .O_wr_addr(wr_addr), .O_wr_data(wr_data),
        .O_wr_num(wr_num), .O_busy(busy), .O_err(err), .O_err_code(err_code),
        .O_err_cnt(err_cnt)
    );

    pxie_rx_cmd_decoder_mc #(.ADDR_W(8)) dut2 (
        .I_PXIE_CLK(clk), .I_Rst(rst), .I_PXIE_DATA(data), .I_PXIE_DATA_VLD(vld),
        .O_Rst(d2_rst), .O_Trig(d2_trig), .O_Run(d2_run), .O_Trig_Num(d2_trig_num),
        .O_Trig_Step(d2_trig_step), .O_c2h_addr(d2_c2h_addr), .O_c2h_len(d2_c2h_len),
        .O_c2h_en(d2_c2h_en), .O_wr_en(d2_wr_en), .O_wr_addr(d2_wr_addr), .O_wr_data(d2_wr_data),
        .O_wr_num(d2_wr_num), .O_busy(d2_busy), .O_err(d2_err), .O_err_code(d2_err_code),
        .O_err_cnt(d2_err_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] hdr(input logic [15:0] h, input logic [15:0] p, input logic [31:0] l);
        logic [127:0] w;
        w = '0;
        w[127:112] = h;
        w[111:96]  = p;
        w[31:0]    = l;
        return w;
    endfunction

    task automatic send(input logic [127:0] w);
        data = w;
        vld  = 1'b1;
        tick();
        vld  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; vld = 1'b0; data = '0;
        tick(); tick();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if ({o_rst, o_trig, o_run, c2h_en, err} !== 5'b0) begin n_fail++; $display("FAIL reset_pulses: got %b want 00000", {o_rst, o_trig, o_run, c2h_en, err}); end
        n_cmp++; if (wr_en !== 4'h0) begin n_fail++; $display("FAIL reset_wr_en: got %h want 0", wr_en); end
        n_cmp++; if ({trig_num, trig_step, err_cnt, err_code} !== 82'h0) begin n_fail++; $display("FAIL reset_regs: got %h want 0", {trig_num, trig_step, err_cnt, err_code}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_params();
        send(hdr(16'hEB9C, 16'd3, 32'h0000_0010));
        n_cmp++; if (trig_num !== 32'h10) begin n_fail++; $display("FAIL trig_num: got %h want 10", trig_num); end
        send(hdr(16'hEB9C, 16'd4, 32'h0000_0002));
        n_cmp++; if (trig_step !== 32'h2) begin n_fail++; $display("FAIL trig_step: got %h want 2", trig_step); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL param_busy: got %b want 0", busy); end
        send(hdr(16'hEB9C, 16'd5, 32'h0040_1234));
        n_cmp++; if ({c2h_len, c2h_addr} !== 32'h0040_1234) begin n_fail++; $display("FAIL c2h_cfg: got %h want 00401234", {c2h_len, c2h_addr}); end
        send(hdr(16'hEB9C, 16'd0, 32'h0000_1010));
        n_cmp++; if (c2h_en !== 1'b1) begin n_fail++; $display("FAIL c2h_en_hi: got %b want 1", c2h_en); end
        tick();
        n_cmp++; if (c2h_en !== 1'b0) begin n_fail++; $display("FAIL c2h_en_lo: got %b want 0", c2h_en); end
        n_cmp++; if ({o_rst, o_trig, o_run, busy, err} !== 5'b0) begin n_fail++; $display("FAIL param_quiet: got %b want 00000", {o_rst, o_trig, o_run, busy, err}); end
    endtask

    task automatic test_pulse();
        int n_trig, n_busy, n_other;
        n_trig = 0; n_busy = 0; n_other = 0;
        send(hdr(16'hEB9C, 16'd0, 32'h0000_0002));
        n_cmp++; if (o_trig !== 1'b1) begin n_fail++; $display("FAIL trig_start: got %b want 1", o_trig); end
        for (int i = 0; i < 60; i++) begin
            if (o_trig) n_trig++;
            if (busy) n_busy++;
            if (o_rst || o_run) n_other++;
            if (i == 10) begin
                data = 128'hDEAD_BEEF;
                vld = 1'b1;
            end
            tick();
            if (i == 10) begin
                vld = 1'b0;
                n_cmp++; if ({err, err_code, err_cnt} !== {1'b1, 2'd3, 16'd1}) begin n_fail++; $display("FAIL overrun: got err=%b code=%0d cnt=%0d want 1/3/1", err, err_code, err_cnt); end
            end
        end
        n_cmp++; if (n_trig != 50) begin n_fail++; $display("FAIL trig_len: got %0d want 50", n_trig); end
        n_cmp++; if (n_busy != 52) begin n_fail++; $display("FAIL pulse_busy: got %0d want 52", n_busy); end
        n_cmp++; if (n_other != 0) begin n_fail++; $display("FAIL pulse_onehot: got %0d want 0", n_other); end
    endtask

    task automatic test_burst();
        logic [127:0] pl [4];
        pl[0] = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        pl[1] = hdr(16'hEB9C, 16'd0, 32'h0000_0001);
        pl[2] = 128'hFFFF_0000_FFFF_0000_A5A5_5A5A_1234_5678;
        pl[3] = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
        send(hdr(16'hEB02, 16'd4, 32'h0000_00FE));
        n_cmp++; if ({busy, wr_num} !== {1'b1, 16'd4}) begin n_fail++; $display("FAIL burst_hdr: got busy=%b num=%0d want 1/4", busy, wr_num); end
        for (int j = 0; j < 4; j++) begin
            for (int g = 0; g <= j; g++) tick();
            n_cmp++; if (wr_en !== 4'h0) begin n_fail++; $display("FAIL burst_gap%0d: got %b want 0000", j, wr_en); end
            send(pl[j]);
            n_cmp++; if (wr_en !== 4'b0100 || wr_addr !== 32'hFE + 32'(j) || wr_data !== pl[j]) begin
                n_fail++; $display("FAIL burst_wr%0d: got en=%b addr=%h data=%h want 0100/%h/%h", j, wr_en, wr_addr, wr_data, 32'hFE + 32'(j), pl[j]);
            end
            n_cmp++; if (o_rst !== 1'b0) begin n_fail++; $display("FAIL burst_norst%0d: got %b want 0", j, o_rst); end
        end
        tick();
        n_cmp++; if ({busy, wr_en, o_rst} !== 6'b0) begin n_fail++; $display("FAIL burst_end: got %b want 000000", {busy, wr_en, o_rst}); end
    endtask

    task automatic test_addr_wrap();
        logic [7:0] ea;
        send(hdr(16'hEB00, 16'd3, 32'h0000_00FF));
        for (int j = 0; j < 3; j++) begin
            send(128'h5A00 + 128'(j));
            ea = 8'hFF + 8'(j);
            n_cmp++; if (d2_wr_en !== 4'b0001 || d2_wr_addr !== ea) begin n_fail++; $display("FAIL wrap%0d: got en=%b addr=%h want 0001/%h", j, d2_wr_en, d2_wr_addr, ea); end
        end
        tick(); tick();
    endtask

    task automatic test_timeout();
        int n_wr, err_at;
        n_wr = 0; err_at = -1;
        send(hdr(16'hEB01, 16'd5, 32'h0000_0100));
        send(128'h1);
        if (wr_en != 4'h0) n_wr++;
        send(128'h2);
        if (wr_en != 4'h0) n_wr++;
        for (int i = 1; i <= 1030; i++) begin
            tick();
            if (wr_en != 4'h0) n_wr++;
            if (err && err_at < 0) err_at = i;
            if (i == 1023) begin
                n_cmp++; if ({busy, err} !== 2'b10) begin n_fail++; $display("FAIL tmo_early: got %b want 10", {busy, err}); end
            end
            if (i == 1024) begin
                n_cmp++; if ({err_code, err_cnt} !== {2'd2, 16'd2}) begin n_fail++; $display("FAIL tmo_code: got code=%0d cnt=%0d want 2/2", err_code, err_cnt); end
            end
            if (i == 1026) begin
                n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_idle: got %b want 0", busy); end
            end
        end
        n_cmp++; if (err_at != 1024) begin n_fail++; $display("FAIL tmo_time: got %0d want 1024", err_at); end
        n_cmp++; if (n_wr != 2) begin n_fail++; $display("FAIL tmo_writes: got %0d want 2", n_wr); end
    endtask

    task automatic test_reset_mid();
        int n_wr;
        n_wr = 0;
        send(hdr(16'hEB03, 16'd4, 32'h0000_0040));
        send(128'h77);
        n_cmp++; if (wr_en !== 4'b1000 || wr_addr !== 32'h40) begin n_fail++; $display("FAIL mid_wr: got en=%b addr=%h want 1000/40", wr_en, wr_addr); end
        tick();
        rst = 1'b1;
        #1;
        n_cmp++; if ({busy, wr_en, err, o_rst, o_trig, o_run} !== 9'b0 || {trig_num, wr_addr, wr_num, err_cnt, err_code} !== 98'h0) begin
            n_fail++; $display("FAIL mid_reset: got busy=%b trig_num=%h wr_addr=%h wr_num=%h err_cnt=%h want all 0", busy, trig_num, wr_addr, wr_num, err_cnt);
        end
        tick();
        rst = 1'b0;
        tick();
        for (int j = 0; j < 3; j++) begin
            send(128'h5555_0000_0000_0000_0000_0000_0000_0000 + 128'(j));
            if (wr_en != 4'h0 || err) n_wr++;
        end
        n_cmp++; if (n_wr != 0) begin n_fail++; $display("FAIL post_reset_writes: got %0d want 0", n_wr); end
        send(hdr(16'hEB07, 16'd2, 32'h0));
        n_cmp++; if ({err, err_code, err_cnt, busy} !== {1'b1, 2'd1, 16'd1, 1'b0}) begin n_fail++; $display("FAIL bad_chan: got err=%b code=%0d cnt=%0d busy=%b want 1/1/1/0", err, err_code, err_cnt, busy); end
        send(hdr(16'hEB9C, 16'd0, 32'h0000_1234));
        n_cmp++; if ({err, err_code, err_cnt} !== {1'b1, 2'd1, 16'd2}) begin n_fail++; $display("FAIL bad_cmd: got err=%b code=%0d cnt=%0d want 1/1/2", err, err_code, err_cnt); end
        tick();
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got %b want 0", err); end
    endtask

    initial begin
        test_reset();
        test_params();
        test_pulse();
        test_burst();
        test_addr_wrap();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pxie_rx_cmd_decoder_mc.md
Name: pxie_rx_cmd_decoder_mc

Overview:
- Next-generation PXIe downstream command decoder.
- Parses valid DATA_W-bit words from the PXIe RX stream into:
  - fixed-length control pulses (reset, trigger, run);
  - trigger parameter registers;
  - a C2H read-config strobe;
  - address-incrementing burst writes into NUM_CH RAM channels.
- Single-clock design; adds a payload-stall timeout, error reporting and a busy flag.
- Sits between the PXIe RX interface and the ISA/system RAMs and trigger logic; any clock-domain crossing of its outputs is done downstream.

Parameters:
- DATA_W, 128, word width; must be ≥128.
- NUM_CH, 4, number of burst-write RAM channels; range 1..8.
- ADDR_W, 32, RAM address width; range ≤32.
- PULSE_LEN, 50, cycles a pulse output stays high; must be ≥1.
- TIMEOUT, 1024, idle cycles allowed inside a burst before abort.

Ports:
- I_PXIE_CLK  in  1  sole clock.
- I_Rst  in  1  asynchronous reset, active-high.
- I_PXIE_DATA  in  DATA_W  RX word; H = bits[DATA_W-1:DATA_W-16], P = bits[111:96], L = bits[31:0].
- I_PXIE_DATA_VLD  in  1  word valid.
- O_Rst  out  1  reset pulse.
- O_Trig  out  1  trigger pulse.
- O_Run  out  1  run pulse.
- O_Trig_Num  out  32  trigger count register.
- O_Trig_Step  out  32  trigger step register.
- O_c2h_addr  out  16  C2H read address.
- O_c2h_len  out  16  C2H read length.
- O_c2h_en  out  1  one-cycle C2H strobe.
- O_wr_en  out  NUM_CH  one-hot write enable.
- O_wr_addr  out  ADDR_W  write address.
- O_wr_data  out  DATA_W  write data.
- O_wr_num  out  16  word count of the current/last burst header.
- O_busy  out  1  high whenever state ≠ IDLE.
- O_err  out  1  one-cycle error pulse.
- O_err_code  out  2  last error code (1 = bad header, 2 = burst timeout, 3 = overrun).
- O_err_cnt  out  16  saturating error count.

Behaviour:
- Reset (I_Rst high, asynchronous): every output and register = 0; state = IDLE. Reset mid-burst or mid-pulse discards the operation. No writes after reset release until a new header arrives.
- States: IDLE, PULSE, BURST, DONE. Only IDLE decodes headers. Words with VLD=0 are ignored in every state.
- IDLE decode (VLD=1), in priority order:
  - H=16'hEB9C and P=3 → O_Trig_Num <= L. Stay in IDLE.
  - H=16'hEB9C and P=4 → O_Trig_Step <= L. Stay in IDLE.
  - H=16'hEB9C and P=5 → O_c2h_addr <= bits[15:0], O_c2h_len <= bits[31:16]. Stay in IDLE.
  - H=16'hEB9C, P∉{3,4,5}, bits[15:0]:
    - 16'h0001 → PULSE(Rst).
    - 16'h0002 → PULSE(Trig).
    - 16'h1100 → PULSE(Run).
    - 16'h1010 → O_c2h_en=1 for the next cycle only; stay in IDLE.
    - Any other value → error 1.
  - H[15:8]=8'hEB with channel c=H[7:0] < NUM_CH:
    - Load addr counter <= bits[ADDR_W-1:0]; O_wr_num <= P; latch c.
    - P=0 → stay in IDLE, no writes, no error.
    - Otherwise → BURST.
  - H[15:8]=8'hEB with c ≥ NUM_CH (excluding 9C) → error 1.
  - H[15:8]≠8'hEB → ignored silently.
- PULSE:
  - Selected output goes high the cycle after header acceptance.
  - It stays high exactly PULSE_LEN cycles, then the FSM goes to DONE.
  - Only one pulse output is high at a time.
- BURST:
  - Every VLD word is payload, including words that look like headers; it is never decoded.
  - Each word gives, on the next cycle: O_wr_en[c]=1, O_wr_addr = current address, O_wr_data = word (latency 1). O_wr_en is 0 on cycles without a write.
  - Address increments after each write and wraps modulo 2^ADDR_W.
  - After the O_wr_num-th word → DONE.
  - A stall counter resets on each VLD. If it reaches TIMEOUT consecutive non-VLD cycles → error 2, go to DONE; words already written stay written.
- DONE: one cycle, all pulse outputs low, stall/pulse counters cleared, then IDLE. DONE also follows every PULSE.
- Overrun: a VLD word arriving in PULSE or DONE is dropped and raises error 3.
- Errors:
  - O_err pulses one cycle, registered the cycle after detection.
  - O_err_code holds the last code.
  - O_err_cnt increments and saturates at 16'hFFFF.
- Registers O_Trig_Num, O_Trig_Step, O_c2h_addr, O_c2h_len and O_wr_num hold their values until rewritten.
- O_busy = (state ≠ IDLE).

Test Plan:
- Send EB9C_0003_…_0000_0010 then EB9C_0004_…_0000_0002 → O_Trig_Num=0x10, O_Trig_Step=2; no pulse; O_busy stays 0.
- Send EB9C…0002 → O_Trig high exactly 50 cycles starting 1 cycle later; O_busy high 52 cycles. A VLD word sent during the pulse → O_err=1, O_err_code=3, O_err_cnt=1.
- Send EB02 header (P=4, addr 0x0000_00FE), then 4 payload words with gaps; one payload word is EB9C…0001 → O_wr_en=4'b0100 four times at addresses 0xFE, 0xFF, 0x100, 0x101 with matching data; no O_Rst pulse.
- Run with ADDR_W=8: EB00 header (P=3, addr 0xFF) plus 3 words → addresses 0xFF, 0x00, 0x01.
- Send EB01 header (P=5), 2 words, then silence → after 1024 idle cycles O_err_code=2, exactly 2 writes, FSM back in IDLE.
- Assert I_Rst during a burst after 1 write → all outputs 0 immediately; words after release with no header produce no writes. EB07 header with NUM_CH=4 → error 1.
